// File: rtl/tor_link_emulator_pkg.sv
// Shared NIC definitions: the internal network packet, the emulator's buffer entry and LFSR constants.
// The entry timestamp width is sized for the default DEPTH/LAT_W pair declared here.
package nic_defs;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] len;
    logic [7:0]  src_id;
    logic [7:0]  dst_id;
  } NetworkPacketInternal;

  localparam int TOR_LINK_DEPTH = 64;
  localparam int TOR_LINK_LAT_W = 16;
  localparam int TOR_LINK_TS_W  =
    ((TOR_LINK_LAT_W > $clog2(TOR_LINK_DEPTH)) ? TOR_LINK_LAT_W : $clog2(TOR_LINK_DEPTH)) + 2;

  typedef struct packed {
    NetworkPacketInternal        pkt;
    logic [TOR_LINK_TS_W-1:0]    ts;
  } t_tor_link_entry;

  localparam logic [15:0] TOR_LINK_LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] TOR_LINK_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] tor_link_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & TOR_LINK_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tor_link_emulator_fifo.sv
// Synchronous FIFO with a registered head copy so the oldest entry is readable while not empty.
// Accepts a push into a full FIFO when a pop happens in the same cycle.
module tor_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push_s, do_pop_s;

  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d  = do_push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The next head comes from memory unless the FIFO drains to the incoming word
    head_d = head_q;
    if (do_pop_s) begin
      if (count_q > (AW+1)'(1)) begin
        head_d = mem_q[rd_ptr_d];
      end else if (do_push_s) begin
        head_d = din;
      end else begin
        head_d = head_q;
      end
    end else if (do_push_s && (count_q == '0)) begin
      head_d = din;
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign head  = head_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/tor_link_emulator.sv
// One-directional emulated ToR link: buffers packets and re-delivers them in order after cfg_latency.
// Optional injected drops are built when TOR_LINK_DROP_INJECT_EN is defined.
module tor_link_emulator
  import nic_defs::*;
#(
  parameter int DEPTH = TOR_LINK_DEPTH,
  parameter int LAT_W = TOR_LINK_LAT_W,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LAT_W-1:0]     cfg_latency,
  input  logic [7:0]           cfg_drop_rate,
  input  NetworkPacketInternal network_tx_in,
  input  logic                 network_tx_valid_in,
  output NetworkPacketInternal network_rx_out,
  output logic                 network_rx_valid_out,
  output logic [CNT_W-1:0]     stat_pkt_in,
  output logic [CNT_W-1:0]     stat_pkt_out,
  output logic [CNT_W-1:0]     stat_drop_full,
  output logic [CNT_W-1:0]     stat_drop_inject
);

  localparam int TS_W = TOR_LINK_TS_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) begin
      return v + 1'b1;
    end else begin
      return v;
    end
  endfunction

  logic [TS_W-1:0]      now_q, now_d;
  logic [TS_W-1:0]      age_s;
  logic [LAT_W-1:0]     lat_eff_s;
  t_tor_link_entry      wr_entry_s, head_s;
  logic                 full_s, empty_s, push_s, pop_s, drop_full_s, drop_inj_s;
  NetworkPacketInternal rx_pkt_q, rx_pkt_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]     in_q, in_d, out_q, out_d, dfull_q, dfull_d;

  tor_link_fifo #(
    .WIDTH ($bits(t_tor_link_entry)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .din     (wr_entry_s),
    .pop     (pop_s),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  always_comb begin
    lat_eff_s = (cfg_latency < LAT_W'(2)) ? LAT_W'(2) : cfg_latency;
    // Modular age stays below 2^TS_W, so the unsigned compare is unambiguous
    age_s       = now_q - head_s.ts;
    pop_s       = !empty_s && (age_s >= TS_W'(lat_eff_s - LAT_W'(1)));
    push_s      = network_tx_valid_in && !drop_inj_s && (!full_s || pop_s);
    drop_full_s = network_tx_valid_in && !drop_inj_s && full_s && !pop_s;
    wr_entry_s.pkt = network_tx_in;
    wr_entry_s.ts  = now_q;
    now_d      = now_q + 1'b1;
    rx_valid_d = pop_s;
    rx_pkt_d   = pop_s ? head_s.pkt : rx_pkt_q;
    in_d       = sat_inc(in_q, network_tx_valid_in);
    out_d      = sat_inc(out_q, pop_s);
    dfull_d    = sat_inc(dfull_q, drop_full_s);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      now_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_pkt_q   <= '0;
      in_q       <= '0;
      out_q      <= '0;
      dfull_q    <= '0;
    end else begin
      now_q      <= now_d;
      rx_valid_q <= rx_valid_d;
      rx_pkt_q   <= rx_pkt_d;
      in_q       <= in_d;
      out_q      <= out_d;
      dfull_q    <= dfull_d;
    end
  end

`ifdef TOR_LINK_DROP_INJECT_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] dinj_q, dinj_d;

  // The drop decision uses the LFSR value held during the strobe cycle
  always_comb begin
    drop_inj_s = network_tx_valid_in && (lfsr_q[7:0] < cfg_drop_rate);
    lfsr_d     = network_tx_valid_in ? tor_link_lfsr_next(lfsr_q) : lfsr_q;
    dinj_d     = sat_inc(dinj_q, drop_inj_s);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= TOR_LINK_LFSR_SEED;
      dinj_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      dinj_q <= dinj_d;
    end
  end

  assign stat_drop_inject = dinj_q;
`else
  logic [7:0] unused_drop_rate_s;
  assign unused_drop_rate_s = cfg_drop_rate;
  assign drop_inj_s         = 1'b0;
  assign stat_drop_inject   = '0;
`endif

  assign network_rx_out       = rx_pkt_q;
  assign network_rx_valid_out = rx_valid_q;
  assign stat_pkt_in          = in_q;
  assign stat_pkt_out         = out_q;
  assign stat_drop_full       = dfull_q;

endmodule

// File: tb/tb_tor_link_emulator.sv
// Randomized self-checking bench for tor_link_emulator against a queue-based delivery model.
// Drop-injection expectations follow TOR_LINK_DROP_INJECT_EN.
module tb_tor_link_emulator;
  import nic_defs::*;

  localparam int DEPTH = 64;
  localparam int LAT_W = 16;
  localparam int CNT_W = 32;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [LAT_W-1:0]     cfg_latency = '0;
  logic [7:0]           cfg_drop_rate = 8'd0;
  NetworkPacketInternal tx_pkt = '0;
  logic                 tx_valid = 1'b0;
  NetworkPacketInternal rx_pkt;
  logic                 rx_valid;
  logic [CNT_W-1:0]     s_in, s_out, s_full, s_inj;

  tor_link_emulator #(.DEPTH(DEPTH), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .cfg_latency          (cfg_latency),
    .cfg_drop_rate        (cfg_drop_rate),
    .network_tx_in        (tx_pkt),
    .network_tx_valid_in  (tx_valid),
    .network_rx_out       (rx_pkt),
    .network_rx_valid_out (rx_valid),
    .stat_pkt_in          (s_in),
    .stat_pkt_out         (s_out),
    .stat_drop_full       (s_full),
    .stat_drop_inject     (s_inj)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    NetworkPacketInternal pkt;
    int                   cyc;
  } rec_t;

  rec_t  obs_q[$];
  rec_t  exp_q[$];
  int    pop_q[$];
  int    last_pop;
  int    m_in, m_full, m_inj, m_acc;
  logic [15:0] m_lfsr;
  int    checks = 0;
  int    errors = 0;

  function automatic NetworkPacketInternal rnd_pkt();
    NetworkPacketInternal p;
    p = {$urandom, $urandom, 16'($urandom), 8'($urandom), 8'($urandom)};
    return p;
  endfunction

  // Model: delivery = max(strobe + L, previous delivery + 1); full = DEPTH held and head not leaving now
  task automatic model_strobe(input NetworkPacketInternal p);
    int   l, pc;
    logic drop;
    l = (cfg_latency < 2) ? 2 : int'(cfg_latency);
    m_in++;
    drop = 1'b0;
`ifdef TOR_LINK_DROP_INJECT_EN
    drop = (m_lfsr[7:0] < cfg_drop_rate);
`endif
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (drop) begin
      m_inj++;
    end else begin
      while (pop_q.size() > 0 && pop_q[0] < cyc) void'(pop_q.pop_front());
      if (pop_q.size() < DEPTH || pop_q[0] == cyc) begin
        pc = (cyc + l - 1 > last_pop + 1) ? cyc + l - 1 : last_pop + 1;
        last_pop = pc;
        pop_q.push_back(pc);
        exp_q.push_back('{p, pc + 1});
        m_acc++;
      end else begin
        m_full++;
      end
    end
  endtask

  task automatic step(input logic v, input NetworkPacketInternal p);
    @(negedge clk);
    if (rx_valid) obs_q.push_back('{rx_pkt, cyc});
    tx_valid = v;
    tx_pkt   = v ? p : '0;
    if (v) model_strobe(p);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      step(1'b0, '0);
      n++;
    end
    repeat (4) step(1'b0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step(1'b0, '0);
    obs_q.delete(); exp_q.delete(); pop_q.delete();
    last_pop = -1000000;
    m_in = 0; m_full = 0; m_inj = 0; m_acc = 0;
    m_lfsr = 16'hACE1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rx_valid !== 1'b0 || rx_pkt !== '0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h, want 0/0", rx_valid, rx_pkt);
    end
    checks++;
    if (s_in !== '0 || s_out !== '0 || s_full !== '0 || s_inj !== '0) begin
      errors++;
      $display("FAIL reset_cnt: %0d %0d %0d %0d, want all 0", s_in, s_out, s_full, s_inj);
    end
  endtask

  task automatic test_single();
    NetworkPacketInternal p;
    int n;
    do_reset();
    cfg_latency = 16'd10;
    repeat (5) step(1'b0, '0);
    p = rnd_pkt();
    step(1'b1, p);
    n = cyc;
    drain(100);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d deliveries, want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].cyc - n !== 10 || obs_q[0].pkt !== p) begin
        errors++;
        $display("FAIL single_pkt: lat %0d data %h, want 10 %h", obs_q[0].cyc - n, obs_q[0].pkt, p);
      end
    end
    checks++;
    if (s_out !== 32'd1) begin
      errors++;
      $display("FAIL single_stat_out: got %0d want 1", s_out);
    end
  endtask

  task automatic test_min_latency();
    NetworkPacketInternal p[4];
    int n0;
    do_reset();
    cfg_latency = 16'd0;
    step(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      p[i] = rnd_pkt();
      step(1'b1, p[i]);
      if (i == 0) n0 = cyc;
    end
    drain(50);
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL minlat_count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== n0 + 2 + i || obs_q[i].pkt !== p[i]) begin
        errors++;
        $display("FAIL minlat_pkt%0d: cyc %0d data %h, want %0d %h", i, obs_q[i].cyc, obs_q[i].pkt, n0 + 2 + i, p[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int n0;
    do_reset();
    cfg_latency = 16'd1000;
    step(1'b0, '0);
    for (int i = 0; i < 80; i++) begin
      step(1'b1, rnd_pkt());
      if (i == 0) n0 = cyc;
    end
    drain(1300);
    checks++;
    if (obs_q.size() !== 64 || exp_q.size() !== 64) begin
      errors++;
      $display("FAIL ovf_count: got %0d model %0d, want 64", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].pkt !== exp_q[i].pkt || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL ovf_pkt%0d: %h@%0d want %h@%0d", i, obs_q[i].pkt, obs_q[i].cyc, exp_q[i].pkt, exp_q[i].cyc);
      end
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].cyc !== n0 + 1000) begin
      errors++;
      $display("FAIL ovf_first_lat: got %0d want 1000", obs_q[0].cyc - n0);
    end
    checks++;
    if (s_full !== 32'd16 || s_in !== 32'd80 || s_out !== 32'd64) begin
      errors++;
      $display("FAIL ovf_stats: full %0d in %0d out %0d, want 16 80 64", s_full, s_in, s_out);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    cfg_latency = 16'd100;
    step(1'b0, '0);
    for (int r = 0; r <= 100; r++) step((r < 64) || (r >= 98), rnd_pkt());
    step(1'b0, '0);
    checks++;
    if (s_full !== 32'd1 || s_in !== 32'd67) begin
      errors++;
      $display("FAIL fullpop_stats: full %0d in %0d, want 1 67", s_full, s_in);
    end
    drain(400);
    checks++;
    if (obs_q.size() !== 66 || exp_q.size() !== 66) begin
      errors++;
      $display("FAIL fullpop_count: got %0d model %0d, want 66", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].pkt !== exp_q[i].pkt || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL fullpop_pkt%0d: %h@%0d want %h@%0d", i, obs_q[i].pkt, obs_q[i].cyc, exp_q[i].pkt, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_latency_change();
    int c;
    do_reset();
    cfg_latency = 16'd500;
    for (int i = 0; i < 10; i++) step(1'b1, rnd_pkt());
    repeat (20) step(1'b0, '0);
    cfg_latency = 16'd3;
    c = cyc;
    // Every buffered packet is already older than the new L, so they drain back to back
    foreach (exp_q[i]) begin
      exp_q[i].cyc = c + 1 + i;
      pop_q[i]     = c + i;
    end
    last_pop = c + 9;
    drain(100);
    checks++;
    if (obs_q.size() !== 10) begin
      errors++;
      $display("FAIL latchg_count: got %0d want 10", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].pkt !== exp_q[i].pkt || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL latchg_pkt%0d: %h@%0d want %h@%0d", i, obs_q[i].pkt, obs_q[i].cyc, exp_q[i].pkt, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_latency = 16'd500;
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, rnd_pkt());
    repeat (10) step(1'b0, '0);
    do_reset();
    checks++;
    if (s_in !== '0 || s_out !== '0 || s_full !== '0 || s_inj !== '0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cnt: %0d %0d %0d %0d v=%b, want 0", s_in, s_out, s_full, s_inj, rx_valid);
    end
    repeat (600) step(1'b0, '0);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_leak: got %0d deliveries after reset, want 0", obs_q.size());
    end
  endtask

  task automatic test_drop_inject();
    logic [CNT_W-1:0] inj0, out0;
    do_reset();
    cfg_latency   = 16'd2;
    cfg_drop_rate = 8'd255;
    for (int i = 0; i < 1000; i++) step(1'b1, rnd_pkt());
    drain(200);
    checks++;
    if (s_inj !== CNT_W'(m_inj) || s_out + s_inj !== 32'd1000 || s_in !== 32'd1000) begin
      errors++;
      $display("FAIL inj_stats: inj %0d out %0d in %0d, want %0d %0d 1000", s_inj, s_out, s_in, m_inj, 1000 - m_inj);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL inj_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].pkt !== exp_q[i].pkt || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL inj_pkt%0d: %h@%0d want %h@%0d", i, obs_q[i].pkt, obs_q[i].cyc, exp_q[i].pkt, exp_q[i].cyc);
      end
    end
    inj0 = s_inj;
    out0 = s_out;
    cfg_drop_rate = 8'd0;
    for (int i = 0; i < 200; i++) step(1'b1, rnd_pkt());
    drain(200);
    checks++;
    if (s_inj !== inj0 || s_out !== out0 + 32'd200) begin
      errors++;
      $display("FAIL inj_rate0: inj %0d out %0d, want %0d %0d", s_inj, s_out, inj0, out0 + 200);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 2; round++) begin
      do_reset();
      cfg_drop_rate = 8'($urandom_range(0, 255));
      cfg_latency   = (round == 0) ? 16'($urandom_range(0, 30)) : 16'($urandom_range(90, 120));
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 99) < ((round == 0) ? 50 : 90), rnd_pkt());
      drain(600);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d want %0d", round, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i].pkt !== exp_q[i].pkt || obs_q[i].cyc !== exp_q[i].cyc) begin
          errors++;
          $display("FAIL rand%0d_pkt%0d: %h@%0d want %h@%0d", round, i, obs_q[i].pkt, obs_q[i].cyc, exp_q[i].pkt, exp_q[i].cyc);
        end
      end
      checks++;
      if (s_in !== CNT_W'(m_in) || s_out !== CNT_W'(m_acc) || s_full !== CNT_W'(m_full) || s_inj !== CNT_W'(m_inj)) begin
        errors++;
        $display("FAIL rand%0d_stats: %0d %0d %0d %0d want %0d %0d %0d %0d", round, s_in, s_out, s_full, s_inj, m_in, m_acc, m_full, m_inj);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_latency();
    test_overflow();
    test_full_pop();
    test_latency_change();
    test_reset_mid();
    test_drop_inject();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
